apb_slave_ctrl: RTL and testbench

- APB slave control front-end.
- Tracks the APB transfer phases (IDLE, SETUP, ACCESS) from PSEL/PENABLE.
- Issues a single-cycle REG_ENABLE strobe to the register bank for each valid access phase.
- Sits between the APB bus interface and the accelerator's register file.
- Also flags protocol violations and counts completed transfers.

---
 rtl/apb_slave_ctrl.sv | 92 +++++++++
 tb/tb_apb_slave_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_ctrl.sv
// APB slave control front-end.
// Follows the IDLE/SETUP/ACCESS transfer phases from PSEL/PENABLE. Each valid
// access phase produces a one-cycle REG_ENABLE strobe toward the register bank
// and bumps a completed-transfer counter. Malformed phase sequences produce a
// one-cycle PSLVERR strobe instead. Every output comes straight from a flop.
module apb_slave_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    output logic                  REG_ENABLE,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] ACCESS_CNT
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  reg_en_q, reg_en_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    // Next state plus next strobe/counter values. The strobes default low so
    // they can only last one cycle, and REG_ENABLE and PSLVERR are raised on
    // disjoint input conditions, so they are never high together.
    always_comb begin
        state_d  = ST_IDLE;
        reg_en_d = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_SETUP;
                end else if (PSEL && PENABLE) begin
                    // Enable arrived without a setup phase.
                    err_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (PSEL && PENABLE) begin
                    state_d  = ST_ACCESS;
                    reg_en_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end else if (PSEL) begin
                    // Setup phase is being extended.
                    state_d = ST_SETUP;
                end else begin
                    // Master abandoned the transfer after setup.
                    err_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Zero wait states: the transfer is already complete here.
                if (PSEL && !PENABLE) begin
                    state_d = ST_SETUP;
                end else if (PSEL && PENABLE) begin
                    // PENABLE held into a second access cycle.
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, strobe and counter registers. The synchronous reset also drops
    // any transfer that is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            reg_en_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            reg_en_q <= reg_en_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign REG_ENABLE = reg_en_q;
    assign PSLVERR    = err_q;
    assign ACCESS_CNT = cnt_q;

endmodule

// File: tb/tb_apb_slave_ctrl.sv
// Testbench for apb_slave_ctrl.
// A transfer-level reference model remembers only whether a setup phase is
// still pending. It predicts the strobes and the counter for each sampled edge.
module tb_apb_slave_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          PSEL;
    logic          PENABLE;
    logic          REG_ENABLE;
    logic          PSLVERR;
    logic [DW-1:0] ACCESS_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit            setup_pending;
    bit            exp_re;
    bit            exp_err;
    int            exp_cnt;

    apb_slave_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .REG_ENABLE (REG_ENABLE),
        .PSLVERR    (PSLVERR),
        .ACCESS_CNT (ACCESS_CNT)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge. Let the rising edge sample
    // them, update the model from the same values, then settle for 1 time unit.
    task automatic step(input bit rst, input bit sel, input bit en);
        @(negedge clk);
        reset   = rst;
        PSEL    = sel;
        PENABLE = en;
        @(posedge clk);
        exp_re  = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            setup_pending = 1'b0;
            exp_cnt       = 0;
        end else if (!sel) begin
            exp_err       = setup_pending;
            setup_pending = 1'b0;
        end else if (!en) begin
            setup_pending = 1'b1;
        end else if (setup_pending) begin
            exp_re        = 1'b1;
            exp_cnt       = (exp_cnt + 1) % (1 << DW);
            setup_pending = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (REG_ENABLE !== 1'b0 || PSLVERR !== 1'b0 || ACCESS_CNT !== '0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got re=%b err=%b cnt=%0d, want 0/0/0",
                         i, REG_ENABLE, PSLVERR, ACCESS_CNT);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (REG_ENABLE !== 1'b0 || PSLVERR !== 1'b0 || ACCESS_CNT !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got re=%b err=%b cnt=%0d, want 0/0/0",
                     REG_ENABLE, PSLVERR, ACCESS_CNT);
        end
    endtask

    task automatic test_single();
        bit seen_re;
        bit seen_err;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (REG_ENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL single_setup_re: got %b, want 0", REG_ENABLE);
        end
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (REG_ENABLE !== 1'b1 || ACCESS_CNT !== 8'd1 || PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL single_access: got re=%b cnt=%0d err=%b, want 1/1/0",
                     REG_ENABLE, ACCESS_CNT, PSLVERR);
        end
        seen_re  = 1'b0;
        seen_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            seen_re  |= REG_ENABLE;
            seen_err |= PSLVERR;
        end
        n_checks++;
        if (seen_re || seen_err || ACCESS_CNT !== 8'd1) begin
            n_fail++;
            $display("FAIL single_after: got re_seen=%b err_seen=%b cnt=%0d, want 0/0/1",
                     seen_re, seen_err, ACCESS_CNT);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int errs;
        int start;
        pulses = 0;
        errs   = 0;
        start  = exp_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (REG_ENABLE !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got re=%b, want 0", i, REG_ENABLE);
            end
            errs += int'(PSLVERR);
            step(1'b0, 1'b1, 1'b1);
            pulses += int'(REG_ENABLE);
            errs   += int'(PSLVERR);
        end
        step(1'b0, 1'b0, 1'b0);
        errs += int'(PSLVERR);
        n_checks++;
        if (pulses != 3 || errs != 0 || int'(ACCESS_CNT) != (start + 3) % 256) begin
            n_fail++;
            $display("FAIL b2b: got pulses=%0d errs=%0d cnt=%0d, want 3/0/%0d",
                     pulses, errs, ACCESS_CNT, (start + 3) % 256);
        end
    endtask

    task automatic test_ext_setup();
        int pulses;
        int errs;
        pulses = 0;
        errs   = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            pulses += int'(REG_ENABLE);
            errs   += int'(PSLVERR);
        end
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (REG_ENABLE !== 1'b1 || pulses != 0) begin
            n_fail++;
            $display("FAIL ext_setup_access: got re=%b early=%0d, want 1/0", REG_ENABLE, pulses);
        end
        step(1'b0, 1'b0, 1'b0);
        pulses += int'(REG_ENABLE);
        errs   += int'(PSLVERR);
        n_checks++;
        if (pulses != 0 || errs != 0 || ACCESS_CNT !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL ext_setup: got extra_re=%0d errs=%0d cnt=%0d, want 0/0/%0d",
                     pulses, errs, ACCESS_CNT, exp_cnt);
        end
    endtask

    task automatic test_errors();
        logic [DW-1:0] c0;
        step(1'b0, 1'b0, 1'b0);
        c0 = ACCESS_CNT;
        // Case 1: enable without setup, starting from idle.
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (PSLVERR !== 1'b1 || REG_ENABLE !== 1'b0 || ACCESS_CNT !== c0) begin
            n_fail++;
            $display("FAIL err_idle_enable: got err=%b re=%b cnt=%0d, want 1/0/%0d",
                     PSLVERR, REG_ENABLE, ACCESS_CNT, c0);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (PSLVERR !== 1'b0) begin
            n_fail++;
            $display("FAIL err_idle_pulse_len: got err=%b, want 0", PSLVERR);
        end
        // Case 2: PSEL dropped during setup.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (PSLVERR !== 1'b1 || REG_ENABLE !== 1'b0 || ACCESS_CNT !== c0) begin
            n_fail++;
            $display("FAIL err_abort: got err=%b re=%b cnt=%0d, want 1/0/%0d",
                     PSLVERR, REG_ENABLE, ACCESS_CNT, c0);
        end
        step(1'b0, 1'b0, 1'b0);
        // Case 3: PENABLE held for a second access cycle.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (PSLVERR !== 1'b1 || REG_ENABLE !== 1'b0 || int'(ACCESS_CNT) != (int'(c0) + 1) % 256) begin
            n_fail++;
            $display("FAIL err_double_access: got err=%b re=%b cnt=%0d, want 1/0/%0d",
                     PSLVERR, REG_ENABLE, ACCESS_CNT, (int'(c0) + 1) % 256);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (PSLVERR !== 1'b0 || REG_ENABLE !== 1'b0) begin
            n_fail++;
            $display("FAIL err_recover: got err=%b re=%b, want 0/0", PSLVERR, REG_ENABLE);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] c0;
        step(1'b0, 1'b0, 1'b0);
        c0 = ACCESS_CNT;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ACCESS_CNT !== c0 || ACCESS_CNT !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL wrap_256: got cnt=%0d, want %0d", ACCESS_CNT, c0);
        end
        // Reset from a nonzero count, then run exactly 256 transfers from zero.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1);
            if (i == 254) begin
                n_checks++;
                if (ACCESS_CNT !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL wrap_max: got cnt=%0d, want 255", ACCESS_CNT);
                end
            end
        end
        n_checks++;
        if (ACCESS_CNT !== 8'h00 || REG_ENABLE !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_zero: got cnt=%0d re=%b, want 0/1", ACCESS_CNT, REG_ENABLE);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (REG_ENABLE !== 1'b0 || PSLVERR !== 1'b0 || ACCESS_CNT !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got re=%b err=%b cnt=%0d, want 0/0/0",
                     REG_ENABLE, PSLVERR, ACCESS_CNT);
        end
        // Back in IDLE: a bare enable is now a protocol error, not an access.
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (REG_ENABLE !== 1'b0 || PSLVERR !== 1'b1 || ACCESS_CNT !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: got re=%b err=%b cnt=%0d, want 0/1/0",
                     REG_ENABLE, PSLVERR, ACCESS_CNT);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (REG_ENABLE !== exp_re || PSLVERR !== exp_err || ACCESS_CNT !== 8'(exp_cnt)) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random[%0d]: got re=%b err=%b cnt=%0d, want %b/%b/%0d",
                             i, REG_ENABLE, PSLVERR, ACCESS_CNT, exp_re, exp_err, exp_cnt);
                bad++;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        PSEL          = 1'b0;
        PENABLE       = 1'b0;
        setup_pending = 1'b0;
        exp_re        = 1'b0;
        exp_err       = 1'b0;
        exp_cnt       = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ext_setup();
        test_errors();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
